// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: one outstanding imem request, redirect flush, decode-stall skid.
// Latency: instruction on id_* the cycle after imem_valid; a stall parks one response in a skid and pauses fetch.
module fetch_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      opcode,
  output logic [2:0]      f3,
  output logic [6:0]      f7
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic            skid_vld_q, skid_vld_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] redirect_tgt;
  logic            id_free;

  assign pc_inc       = pc_q + XLEN'(4);
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
  assign id_free      = !stall || !id_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    skid_vld_d   = skid_vld_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (redirect) begin
      // Redirect wins over stall and any same-cycle response.
      pc_d       = redirect_tgt;
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      skid_vld_d = 1'b0;
      unique case (state_q)
        FETCH: begin
          if (!imem_valid) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end
        HOLD:    state_d = FETCH;
        default: state_d = DRAIN;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_valid) begin
            pc_d = pc_inc;
            if (id_free) begin
              id_valid_d = 1'b1;
              id_pc_d    = pc_q;
              id_instr_d = imem_rdata;
            end else begin
              skid_vld_d   = 1'b1;
              skid_pc_d    = pc_q;
              skid_instr_d = imem_rdata;
              state_d      = HOLD;
            end
          end else if (!stall && id_valid_q) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_valid_d = skid_vld_q;
            id_pc_d    = skid_pc_q;
            id_instr_d = skid_vld_q ? skid_instr_q : NOP_INSTR;
            skid_vld_d = 1'b0;
            state_d    = FETCH;
          end
        end
        default: begin
          // Stale response for the abandoned address is dropped here.
          if (imem_valid) begin
            state_d = FETCH;
          end
          if (!stall && id_valid_q) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= NOP_INSTR;
      skid_vld_q   <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
      skid_vld_q   <= skid_vld_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign imem_req  = !rst && (state_q != HOLD);
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
  assign opcode   = id_instr_q[6:0];
  assign f3       = id_instr_q[14:12];
  assign f7       = id_instr_q[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: 0-latency, 3-cycle-latency and hand-driven imem responders.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;

  logic        imem_req2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        id_valid2;
  logic [31:0] id_pc2, id_instr2;
  logic [6:0]  opcode2, f72;
  logic [2:0]  f32;

  // 0: zero-latency, 1: latency 3, 2: manual
  int          mode;
  logic        man_vld;
  logic [31:0] man_rdata;
  logic        lat_vld;
  int          lat_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  assign imem_valid  = (mode == 0) ? imem_req : ((mode == 1) ? lat_vld : man_vld);
  assign imem_rdata  = (mode == 2) ? man_rdata : tag(imem_addr);
  assign imem_rdata2 = tag(imem_addr2);

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .opcode(opcode), .f3(f3), .f7(f7)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_req2), .imem_rdata(imem_rdata2),
    .stall(stall), .redirect(1'b0), .redirect_pc(32'h0),
    .id_valid(id_valid2), .id_pc(id_pc2), .id_instr(id_instr2),
    .opcode(opcode2), .f3(f32), .f7(f72)
  );

  always #5 clk = ~clk;

  // Latency-3 memory: counts requested cycles, strobes once, then restarts.
  always @(negedge clk) begin
    if (rst || mode != 1) begin
      lat_vld = 1'b0;
      lat_cnt = 0;
    end else if (lat_vld) begin
      lat_vld = 1'b0;
      lat_cnt = 0;
    end else if (imem_req) begin
      lat_cnt = lat_cnt + 1;
      if (lat_cnt >= 3) lat_vld = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; man_vld = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    man_vld = 1'b0; man_rdata = '0; mode = 0;

    // Reset values and zero-latency streaming
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req_wrap", 32'(imem_req2), 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    chk("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
    tick();
    chk("s0_valid", 32'(id_valid), 32'd1);
    chk("s0_pc", id_pc, 32'h0);
    chk("s0_instr", id_instr, 32'hA500_0000);
    chk("s0_addr", imem_addr, 32'h4);
    chk("wrap_id_pc", id_pc2, 32'hFFFF_FFFC);
    chk("wrap_instr", id_instr2, 32'hA5FF_FFFC);
    chk("wrap_second_addr", imem_addr2, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("stream_pc", id_pc, 32'(4 * k));
      chk("stream_valid", 32'(id_valid), 32'd1);
      chk("stream_instr", id_instr, 32'hA500_0000 | 32'(4 * k));
    end

    // R-type decode slices
    mode = 2;
    do_reset();
    man_vld = 1'b1; man_rdata = 32'h0031_00B3;
    tick();
    man_vld = 1'b0;
    chk("rtype_opcode", 32'(opcode), 32'h33);
    chk("rtype_f3", 32'(f3), 32'h0);
    chk("rtype_f7", 32'(f7), 32'h0);
    chk("rtype_pc", id_pc, 32'h0);
    tick();
    chk("bubble_valid", 32'(id_valid), 32'd0);
    chk("bubble_instr", id_instr, 32'h0000_0013);

    // Stall with a returning response parks it in the skid
    man_vld = 1'b1; man_rdata = 32'h0050_0093;
    tick();
    chk("pre_stall_instr", id_instr, 32'h0050_0093);
    chk("pre_stall_pc", id_pc, 32'h4);
    stall = 1'b1; man_rdata = 32'h4020_8033;
    tick();
    man_vld = 1'b0;
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_instr", id_instr, 32'h0050_0093);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hold_req_n", 32'(imem_req), 32'd0);
      chk("hold_instr_n", id_instr, 32'h0050_0093);
      chk("hold_valid_n", 32'(id_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    chk("release_instr", id_instr, 32'h4020_8033);
    chk("release_f7", 32'(f7), 32'h20);
    chk("release_pc", id_pc, 32'h8);
    chk("release_valid", 32'(id_valid), 32'd1);
    chk("release_req", 32'(imem_req), 32'd1);
    chk("release_addr", imem_addr, 32'hC);

    // Redirect while a 3-cycle request is outstanding
    mode = 1;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    chk("drain_addr", imem_addr, 32'h0);
    chk("drain_req", 32'(imem_req), 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (imem_addr == 32'h100) break;
      chk("drain_no_id", 32'(id_valid), 32'd0);
      tick();
    end
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_still_empty", 32'(id_valid), 32'd0);
    for (int k = 0; k < 10; k++) begin
      if (id_valid) break;
      tick();
    end
    chk("redir_valid", 32'(id_valid), 32'd1);
    chk("redir_pc", id_pc, 32'h100);
    chk("redir_instr", id_instr, 32'hA500_0100);

    // Redirect, response and stall in the same cycle
    mode = 2;
    do_reset();
    man_vld = 1'b1; man_rdata = 32'h0010_0093;
    tick();
    chk("pre_redir_valid", 32'(id_valid), 32'd1);
    stall = 1'b1; man_rdata = 32'h4020_8033; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    man_vld = 1'b0; redirect = 1'b0;
    chk("same_valid", 32'(id_valid), 32'd0);
    chk("same_instr", id_instr, 32'h0000_0013);
    chk("same_addr", imem_addr, 32'h200);
    chk("same_req", 32'(imem_req), 32'd1);
    tick();
    chk("same_after_valid", 32'(id_valid), 32'd0);
    chk("same_after_addr", imem_addr, 32'h200);
    stall = 1'b0;

    // Reset asserted mid-HOLD
    do_reset();
    man_vld = 1'b1; man_rdata = 32'h0010_0093;
    tick();
    stall = 1'b1; man_rdata = 32'h0020_0113;
    tick();
    man_vld = 1'b0;
    chk("mid_hold_req", 32'(imem_req), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_instr", id_instr, 32'h0000_0013);
    chk("mid_rst_pc", id_pc, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    #1;
    chk("mid_rst_fetch", 32'(imem_req), 32'd1);
    stall = 1'b0;
    tick();
    chk("mid_rst_refetch_pc", id_pc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
